// File: rtl/watch_pkg.sv
// Shared encodings, limits and clamp helpers for the multi-alarm watch core.
// The optional snooze feature is enabled by defining WATCH_SNOOZE_EN.
package watch_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRing   = 2'd1,
        StSnooze = 2'd2
    } alarm_state_e;

    localparam logic [4:0] MAX_HOUR = 5'd23;
    localparam logic [5:0] MAX_MIN  = 6'd59;
    localparam logic [5:0] MAX_SEC  = 6'd59;

    localparam int unsigned SNOOZE_MINUTES = 5;

    function automatic logic [4:0] clamp_hour(input logic [4:0] h);
        return (h > MAX_HOUR) ? MAX_HOUR : h;
    endfunction

    function automatic logic [5:0] clamp_min_sec(input logic [5:0] v);
        return (v > MAX_MIN) ? MAX_MIN : v;
    endfunction

endpackage

// File: rtl/watch_tick_prescaler.sv
// Free-running divider: tick is high while the count sits at DIV-1; clear restarts from 0.
module watch_tick_prescaler #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == CntLast)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/watch_core_multi_alarm.sv
// 24-hour timekeeper with NUM_ALARMS armed alarm slots, each running an IDLE/RING(/SNOOZE) FSM.
// Define WATCH_SNOOZE_EN to build the SNOOZE state and its per-slot minute counters.
module watch_core_multi_alarm
    import watch_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 17_000_000,
    parameter int unsigned NUM_ALARMS   = 2,
    parameter int unsigned FLASH_DIV    = 8_500_000,
    parameter int unsigned RING_SECONDS = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  time_load,
    input  logic [4:0]            time_hours,
    input  logic [5:0]            time_minutes,
    input  logic [5:0]            time_seconds,
    input  logic                  alarm_wr,
    input  logic [2:0]            alarm_idx,
    input  logic [4:0]            alarm_hours,
    input  logic [5:0]            alarm_minutes,
    input  logic                  alarm_arm,
    input  logic                  alarm_ack,
    input  logic                  snooze,
    output logic [5:0]            second_count,
    output logic [5:0]            minute_count,
    output logic [4:0]            hour_count,
    output logic                  tick_1hz,
    output logic [NUM_ALARMS-1:0] alarm_ringing,
    output logic                  alarm_flash
);

    localparam logic [7:0] RingLast = 8'(RING_SECONDS - 1);

    logic       tick, flash_tick, any_ring, minute_edge;
    logic [5:0] sec_q, sec_d, min_q, min_d;
    logic [4:0] hour_q, hour_d;
    logic       flash_q, flash_d;

    alarm_state_e state_q [NUM_ALARMS];
    alarm_state_e state_d [NUM_ALARMS];
    logic [7:0]   ring_cnt_q [NUM_ALARMS];
    logic [7:0]   ring_cnt_d [NUM_ALARMS];
    logic [4:0]   al_hour_q [NUM_ALARMS];
    logic [4:0]   al_hour_d [NUM_ALARMS];
    logic [5:0]   al_min_q [NUM_ALARMS];
    logic [5:0]   al_min_d [NUM_ALARMS];
    logic         al_arm_q [NUM_ALARMS];
    logic         al_arm_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] match, wr_hit;

`ifdef WATCH_SNOOZE_EN
    localparam logic [3:0] SnoozeLast = 4'(SNOOZE_MINUTES - 1);
    logic [3:0] snz_cnt_q [NUM_ALARMS];
    logic [3:0] snz_cnt_d [NUM_ALARMS];
`else
    logic unused_snooze;
    assign unused_snooze = snooze;
`endif

    watch_tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_sec_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (time_load),
        .tick  (tick)
    );

    // Held in reset whenever no slot rings so every ring starts flashing from a known phase.
    watch_tick_prescaler #(
        .DIV (FLASH_DIV)
    ) u_flash_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (!any_ring),
        .tick  (flash_tick)
    );

    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (time_load) begin
            sec_d  = clamp_min_sec(time_seconds);
            min_d  = clamp_min_sec(time_minutes);
            hour_d = clamp_hour(time_hours);
        end else if (tick) begin
            if (sec_q == MAX_SEC) begin
                sec_d = '0;
                if (min_q == MAX_MIN) begin
                    min_d  = '0;
                    hour_d = (hour_q == MAX_HOUR) ? '0 : hour_q + 1'b1;
                end else begin
                    min_d = min_q + 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end
    end

    // A load overrides the tick, so only a genuine advance can land on second 0.
    assign minute_edge = tick && !time_load && (sec_q == MAX_SEC);

    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            wr_hit[i] = alarm_wr && (alarm_idx == 3'(i));
            match[i]  = minute_edge && al_arm_q[i] && (al_hour_q[i] == hour_d)
                        && (al_min_q[i] == min_d);
            al_hour_d[i] = wr_hit[i] ? clamp_hour(alarm_hours) : al_hour_q[i];
            al_min_d[i]  = wr_hit[i] ? clamp_min_sec(alarm_minutes) : al_min_q[i];
            al_arm_d[i]  = wr_hit[i] ? alarm_arm : al_arm_q[i];
        end
    end

    // Alarm FSM next-state logic.
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            state_d[i]    = state_q[i];
            ring_cnt_d[i] = ring_cnt_q[i];
`ifdef WATCH_SNOOZE_EN
            snz_cnt_d[i]  = snz_cnt_q[i];
`endif
            if (wr_hit[i]) begin
                state_d[i]    = StIdle;
                ring_cnt_d[i] = '0;
            end else begin
                case (state_q[i])
                    StIdle: begin
                        if (match[i] && !alarm_ack) begin
                            state_d[i]    = StRing;
                            ring_cnt_d[i] = '0;
                        end
                    end
                    StRing: begin
                        if (alarm_ack) begin
                            state_d[i] = StIdle;
`ifdef WATCH_SNOOZE_EN
                        end else if (snooze) begin
                            state_d[i]   = StSnooze;
                            snz_cnt_d[i] = '0;
`endif
                        end else if (tick) begin
                            if (ring_cnt_q[i] == RingLast) begin
                                state_d[i] = StIdle;
                            end else begin
                                ring_cnt_d[i] = ring_cnt_q[i] + 1'b1;
                            end
                        end
                    end
`ifdef WATCH_SNOOZE_EN
                    StSnooze: begin
                        if (alarm_ack) begin
                            state_d[i] = StIdle;
                        end else if (minute_edge) begin
                            if (snz_cnt_q[i] == SnoozeLast) begin
                                state_d[i]    = StRing;
                                ring_cnt_d[i] = '0;
                            end else begin
                                snz_cnt_d[i] = snz_cnt_q[i] + 1'b1;
                            end
                        end
                    end
`endif
                    default: state_d[i] = StIdle;
                endcase
            end
        end
    end

    // Alarm FSM outputs.
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            alarm_ringing[i] = (state_q[i] == StRing);
        end
        any_ring = |alarm_ringing;
        flash_d  = any_ring ? (flash_q ^ flash_tick) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            flash_q <= 1'b0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                state_q[i]    <= StIdle;
                ring_cnt_q[i] <= '0;
                al_hour_q[i]  <= '0;
                al_min_q[i]   <= '0;
                al_arm_q[i]   <= 1'b0;
`ifdef WATCH_SNOOZE_EN
                snz_cnt_q[i]  <= '0;
`endif
            end
        end else begin
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            flash_q <= flash_d;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                state_q[i]    <= state_d[i];
                ring_cnt_q[i] <= ring_cnt_d[i];
                al_hour_q[i]  <= al_hour_d[i];
                al_min_q[i]   <= al_min_d[i];
                al_arm_q[i]   <= al_arm_d[i];
`ifdef WATCH_SNOOZE_EN
                snz_cnt_q[i]  <= snz_cnt_d[i];
`endif
            end
        end
    end

    assign second_count = sec_q;
    assign minute_count = min_q;
    assign hour_count   = hour_q;
    assign tick_1hz     = tick;
    assign alarm_flash  = flash_q;

endmodule

// File: tb/tb_watch_core_multi_alarm.sv
// Bench for watch_core_multi_alarm: seconds-of-day reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_watch_core_multi_alarm;

    localparam int TICK_DIV     = 4;
    localparam int NUM_ALARMS   = 2;
    localparam int FLASH_DIV    = 2;
    localparam int RING_SECONDS = 3;
    localparam int SNZ_MIN      = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       time_load = 1'b0;
    logic [4:0] time_hours = '0;
    logic [5:0] time_minutes = '0;
    logic [5:0] time_seconds = '0;
    logic       alarm_wr = 1'b0;
    logic [2:0] alarm_idx = '0;
    logic [4:0] alarm_hours = '0;
    logic [5:0] alarm_minutes = '0;
    logic       alarm_arm = 1'b0;
    logic       alarm_ack = 1'b0;
    logic       snooze = 1'b0;
    logic [5:0] second_count, minute_count;
    logic [4:0] hour_count;
    logic       tick_1hz, alarm_flash;
    logic [NUM_ALARMS-1:0] alarm_ringing;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    watch_core_multi_alarm #(
        .TICK_DIV     (TICK_DIV),
        .NUM_ALARMS   (NUM_ALARMS),
        .FLASH_DIV    (FLASH_DIV),
        .RING_SECONDS (RING_SECONDS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .time_load     (time_load),
        .time_hours    (time_hours),
        .time_minutes  (time_minutes),
        .time_seconds  (time_seconds),
        .alarm_wr      (alarm_wr),
        .alarm_idx     (alarm_idx),
        .alarm_hours   (alarm_hours),
        .alarm_minutes (alarm_minutes),
        .alarm_arm     (alarm_arm),
        .alarm_ack     (alarm_ack),
        .snooze        (snooze),
        .second_count  (second_count),
        .minute_count  (minute_count),
        .hour_count    (hour_count),
        .tick_1hz      (tick_1hz),
        .alarm_ringing (alarm_ringing),
        .alarm_flash   (alarm_flash)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference model: time as seconds of day, ring/snooze as remaining-count timers,
    // flash phase derived from how long something has been ringing.
    int tod, pre, ring_age;
    int st [NUM_ALARMS];
    int rleft [NUM_ALARMS];
    int sleft [NUM_ALARMS];
    int ah [NUM_ALARMS];
    int am [NUM_ALARMS];
    bit arm [NUM_ALARMS];
    bit m_tick, m_any, m_medge, m_hit;
    int nt;

    always @(posedge clk) begin
        if (reset) begin
            tod = 0; pre = 0; ring_age = 0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                st[i] = 0; rleft[i] = 0; sleft[i] = 0; ah[i] = 0; am[i] = 0; arm[i] = 0;
            end
        end else begin
            m_tick = (pre == TICK_DIV - 1);
            m_any = 0;
            for (int i = 0; i < NUM_ALARMS; i++) if (st[i] == 1) m_any = 1;
            ring_age = m_any ? ring_age + 1 : 0;
            nt = tod;
            m_medge = 0;
            if (time_load) begin
                nt = clampv(time_hours, 23) * 3600 + clampv(time_minutes, 59) * 60
                     + clampv(time_seconds, 59);
                pre = 0;
            end else begin
                if (m_tick) begin
                    nt = (tod + 1) % 86400;
                    m_medge = (nt % 60 == 0);
                end
                pre = (pre + 1) % TICK_DIV;
            end
            for (int i = 0; i < NUM_ALARMS; i++) begin
                m_hit = m_medge && arm[i] && (nt / 3600 == ah[i]) && ((nt / 60) % 60 == am[i]);
                if (alarm_wr && int'(alarm_idx) == i) begin
                    st[i] = 0;
                    ah[i] = clampv(alarm_hours, 23);
                    am[i] = clampv(alarm_minutes, 59);
                    arm[i] = alarm_arm;
                end else if (st[i] == 0) begin
                    if (m_hit && !alarm_ack) begin
                        st[i] = 1; rleft[i] = RING_SECONDS;
                    end
                end else if (st[i] == 1) begin
                    if (alarm_ack) st[i] = 0;
`ifdef WATCH_SNOOZE_EN
                    else if (snooze) begin
                        st[i] = 2; sleft[i] = SNZ_MIN;
                    end
`endif
                    else if (m_tick) begin
                        rleft[i]--;
                        if (rleft[i] == 0) st[i] = 0;
                    end
                end else begin
                    if (alarm_ack) st[i] = 0;
                    else if (m_medge) begin
                        sleft[i]--;
                        if (sleft[i] == 0) begin
                            st[i] = 1; rleft[i] = RING_SECONDS;
                        end
                    end
                end
            end
            tod = nt;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_sec", second_count, tod % 60);
            chk("model_min", minute_count, (tod / 60) % 60);
            chk("model_hour", hour_count, tod / 3600);
            chk("model_tick", tick_1hz, int'(pre == TICK_DIV - 1));
            chk("model_ringing", alarm_ringing, {st[1] == 1, st[0] == 1});
            chk("model_flash", alarm_flash, (ring_age / FLASH_DIV) % 2);
        end
    end

    task automatic load_time(input int h, input int m, input int s);
        time_hours = 5'(h); time_minutes = 6'(m); time_seconds = 6'(s);
        time_load = 1'b1;
        @(negedge clk);
        time_load = 1'b0;
    endtask

    task automatic write_alarm(input int idx, input int h, input int m, input bit a);
        alarm_idx = 3'(idx); alarm_hours = 5'(h); alarm_minutes = 6'(m); alarm_arm = a;
        alarm_wr = 1'b1;
        @(negedge clk);
        alarm_wr = 1'b0;
    endtask

    task automatic pulse_ack();
        alarm_ack = 1'b1;
        @(negedge clk);
        alarm_ack = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        while (!tick_1hz && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!tick_1hz) chk("tick_timeout", tick_1hz, 1);
    endtask

    task automatic next_sec();
        int n;
        wait_tick(n);
        @(negedge clk);
    endtask

    task automatic chk_time(input string name, input int h, input int m, input int s);
        chk({name, "_h"}, hour_count, h);
        chk({name, "_m"}, minute_count, m);
        chk({name, "_s"}, second_count, s);
    endtask

    initial begin
        int n;
        int flash_exp [5];
        flash_exp = '{0, 0, 1, 1, 0};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Reset in the middle of a count.
        repeat (5) @(negedge clk);
        load_time(12, 34, 56);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_time("reset", 0, 0, 0);
        chk("reset_tick", tick_1hz, 0);
        chk("reset_ringing", alarm_ringing, 0);
        chk("reset_flash", alarm_flash, 0);
        reset = 1'b0;

        // Midnight wrap and tick cadence.
        load_time(23, 59, 58);
        chk_time("load", 23, 59, 58);
        wait_tick(n);
        chk("tick_after_load", n, 3);
        @(negedge clk);
        chk_time("wrap1", 23, 59, 59);
        wait_tick(n);
        chk("tick_period", n + 1, TICK_DIV);
        @(negedge clk);
        chk_time("wrap2", 0, 0, 0);

        // Slot 1 rings, flashes, then times out.
        write_alarm(1, 0, 1, 1);
        load_time(0, 0, 59);
        next_sec();
        chk("ring_slot1", alarm_ringing, 2);
        chk_time("ring_slot1", 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            chk("flash_seq", alarm_flash, flash_exp[k]);
            @(negedge clk);
        end
        n = 0;
        while (alarm_ringing != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ring_timeout_ringing", alarm_ringing, 0);
        chk("ring_timeout_sec", second_count, RING_SECONDS);
        chk("ring_timeout_flash", alarm_flash, 0);

        // Acknowledge dismisses, with no retrigger in the same minute.
        write_alarm(0, 0, 2, 1);
        write_alarm(1, 0, 1, 0);
        load_time(0, 1, 59);
        next_sec();
        chk("ring_slot0", alarm_ringing, 1);
        pulse_ack();
        chk("ack_dismiss", alarm_ringing, 0);
        repeat (3) next_sec();
        chk("no_retrigger", alarm_ringing, 0);

        // Ack coinciding with the match keeps the slot idle.
        write_alarm(0, 0, 3, 1);
        load_time(0, 2, 59);
        alarm_ack = 1'b1;
        next_sec();
        alarm_ack = 1'b0;
        chk("ack_beats_match", alarm_ringing, 0);

        // Clamping of loads and alarm writes; out-of-range slot index.
        load_time(29, 62, 63);
        chk_time("clamp_load", 23, 59, 59);
        write_alarm(5, 0, 0, 1);
        next_sec();
        chk("bad_idx_ignored", alarm_ringing, 0);
        write_alarm(0, 30, 63, 1);
        load_time(23, 58, 59);
        next_sec();
        chk("alarm_clamp", alarm_ringing, 1);
        pulse_ack();
        chk("alarm_clamp_ack", alarm_ringing, 0);

        // Snooze.
        write_alarm(0, 0, 5, 1);
        load_time(0, 4, 59);
        next_sec();
        chk("snooze_pre", alarm_ringing, 1);
        snooze = 1'b1;
        @(negedge clk);
        snooze = 1'b0;
`ifdef WATCH_SNOOZE_EN
        chk("snooze_silences", alarm_ringing, 0);
        n = 0;
        while (alarm_ringing[0] != 1'b1 && n < 1400) begin
            @(negedge clk);
            n++;
        end
        chk("snooze_reringing", alarm_ringing, 1);
        chk_time("snooze_rering", 0, 10, 0);
`else
        chk("snooze_ignored", alarm_ringing, 1);
`endif
        pulse_ack();
        chk("final_ack", alarm_ringing, 0);
        repeat (4) @(negedge clk);
        chk("final_flash", alarm_flash, 0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
